unidade_controle_rodadas: RTL
=============================

// Module: unidade_controle_rodadas
// PURPOSE
//  Moore FSM sequencing the memory-game datapath: prepares counters, runs round N
//  (player repeats plays 0..N), advances rounds, and ends in win, wrong-play or timeout.
//  Sits between top-level pins (iniciar) and the fluxo_dados counters/register/comparator.
//  Owns the per-play timeout counter, which counts only while waiting for a play.
// PARAMETERS
//  TIMEOUT_CYCLES  5000  clocks allowed per play while waiting (5 s at 1 kHz); must be >= 2
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  asynchronous, active-high; forces INICIAL and clears timeout count
//  iniciar     in   1  start/restart request, level-sampled
//  jogada      in   1  one-cycle pulse from datapath edge detector: a button was pressed
//  igual       in   1  comparator: registered play == memory word
//  fim_e       in   1  play counter == round limit (last play of round)
//  fim_l       in   1  round counter at last round
//  zera_e      out  1  clear play counter
//  conta_e     out  1  increment play counter
//  zera_l      out  1  clear round counter
//  conta_l     out  1  increment round counter
//  zera_r      out  1  clear play register
//  registra_r  out  1  load play register
//  acertou     out  1  game won (held in FIM_ACERTO)
//  errou       out  1  game lost: wrong play or timeout
//  pronto      out  1  game over, any end state
//  timeout     out  1  high in FIM_TIMEOUT
//  db_estado   out  4  current state code for hex display
// BEHAVIOUR
//  - Moore outputs: combinational decode of state register; asserted during the cycle in state.
//  - Reset: state=INICIAL(0x0); all outputs 0 except db_estado=0x0; timeout count=0.
//  - States/transitions (code):
//    INICIAL(0): iniciar -> PREPARA, else stay
//    PREPARA(1): zera_l, zera_e, zera_r -> INICIA_RODADA
//    INICIA_RODADA(2): zera_e -> ESPERA
//    ESPERA(3): timeout count +1/cycle; jogada -> REGISTRA; count==TIMEOUT_CYCLES-1 and
//      no jogada -> FIM_TIMEOUT (at TIMEOUT_CYCLES cycles in ESPERA); jogada beats timeout in same cycle
//    REGISTRA(4): registra_r -> COMPARA
//    COMPARA(5): !igual -> FIM_ERRO; igual&!fim_e -> PROX_JOGADA;
//      igual&fim_e&!fim_l -> PROX_RODADA; igual&fim_e&fim_l -> FIM_ACERTO
//    PROX_JOGADA(6): conta_e -> ESPERA
//    PROX_RODADA(7): conta_l -> INICIA_RODADA
//    FIM_ACERTO(0xA): acertou, pronto;  FIM_ERRO(0xE): errou, pronto;
//    FIM_TIMEOUT(0xD): errou, pronto, timeout;  all end states: iniciar -> PREPARA, else stay
//  - Timeout counter: cleared in every state other than ESPERA, so each play gets a full window;
//    width $clog2(TIMEOUT_CYCLES); saturates, never wraps.
//  - iniciar ignored in states 1-7 (no restart mid-game); only reset aborts a game.
//  - Reset mid-game: immediate return to INICIAL, counters resumed only via PREPARA.
//  - Unused state codes -> INICIAL next cycle.
//  - jogada sampled only in ESPERA; pulses elsewhere dropped.
// CONFIGURATION
//  CTRL_TIMEOUT_EN defined: ESPERA timeout path and FIM_TIMEOUT present as above.
//  Not defined: timeout counter and FIM_TIMEOUT removed; ESPERA waits indefinitely;
//    timeout output tied 0; TIMEOUT_CYCLES unused.
// STRUCTURE
//  Shared include jogo_pkg.vh: 4-bit state code localparams (INICIAL..FIM_TIMEOUT) used by
//    this FSM, hex-display decoder and benches.
//  One sub-module: contador_timeout (param M=TIMEOUT_CYCLES; clock, reset, zera, conta, fim).
// TESTING (bench TIMEOUT_CYCLES=20, CTRL_TIMEOUT_EN defined unless noted)
//  1 reset pulse -> db_estado=0x0, all control/result outputs 0; iniciar=1 1 clk -> 1,2,3 seq.
//  2 round 0: fim_e=1,igual=1,fim_l=0, jogada pulse -> 4,5,7(conta_l=1 one clk),2,3.
//  3 fim_e=1,fim_l=1,igual=1, jogada -> 0xA, acertou=pronto=1; iniciar -> PREPARA(1).
//  4 in ESPERA, igual=0, jogada -> 4,5,0xE with errou=pronto=1, acertou=0.
//  5 idle in ESPERA 19 clks -> still 3; 20th -> 0xD, timeout=errou=pronto=1; jogada on the
//    20th cycle -> REGISTRA instead. Macro undefined: 100 idle clks -> still 3, timeout=0.
//  6 reset asserted mid-COMPARA (async, between edges) -> state 0x0 before next edge;
//    iniciar held in ESPERA -> no change.

Source files
------------

// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the memory-game round controller.
// The 4-bit state codes are also the values shown on the hex display.
package unidade_controle_rodadas_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIA_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        FIM_ACERTO    = 4'hA,
        FIM_TIMEOUT   = 4'hD,
        FIM_ERRO      = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play timeout counter: counts while enabled, clears on zera,
// saturates at M-1 and flags fim while sitting there.
module unidade_controle_rodadas_contador_timeout #(
    parameter int M = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = $clog2(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    // Saturating count; zera has priority so every play starts a fresh window.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta && (contagem != ULTIMO)) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore FSM sequencing the memory-game datapath: prepare, play rounds,
// and finish on win, wrong play or (optionally) per-play timeout.
// Define CTRL_TIMEOUT_EN to build the ESPERA timeout path and FIM_TIMEOUT.
module unidade_controle_rodadas
    import unidade_controle_rodadas_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_e,
    input  logic       fim_l,
    output logic       zera_e,
    output logic       conta_e,
    output logic       zera_l,
    output logic       conta_l,
    output logic       zera_r,
    output logic       registra_r,
    output logic       acertou,
    output logic       errou,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // The timeout window needs at least one counting cycle before expiry.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_invalido
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    estado_t estado;
    estado_t prox_estado;

`ifdef CTRL_TIMEOUT_EN
    logic fim_timeout;

    unidade_controle_rodadas_contador_timeout #(
        .M(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ESPERA),
        .conta (estado == ESPERA),
        .fim   (fim_timeout)
    );
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic; unused codes fall back to INICIAL.
    // NOTE: prox_estado gets a default before the case so no path can infer a latch.
    always_comb begin
        prox_estado = INICIAL;
        case (estado)
            INICIAL:       prox_estado = iniciar ? PREPARA : INICIAL;
            PREPARA:       prox_estado = INICIA_RODADA;
            INICIA_RODADA: prox_estado = ESPERA;
            ESPERA: begin
                prox_estado = ESPERA;
                if (jogada) begin
                    prox_estado = REGISTRA;
                end
`ifdef CTRL_TIMEOUT_EN
                else if (fim_timeout) begin
                    prox_estado = FIM_TIMEOUT;
                end
`endif
            end
            REGISTRA:      prox_estado = COMPARA;
            COMPARA: begin
                if (!igual)      prox_estado = FIM_ERRO;
                else if (!fim_e) prox_estado = PROX_JOGADA;
                else if (!fim_l) prox_estado = PROX_RODADA;
                else             prox_estado = FIM_ACERTO;
            end
            PROX_JOGADA:   prox_estado = ESPERA;
            PROX_RODADA:   prox_estado = INICIA_RODADA;
            FIM_ACERTO:    prox_estado = iniciar ? PREPARA : FIM_ACERTO;
            FIM_ERRO:      prox_estado = iniciar ? PREPARA : FIM_ERRO;
`ifdef CTRL_TIMEOUT_EN
            FIM_TIMEOUT:   prox_estado = iniciar ? PREPARA : FIM_TIMEOUT;
`endif
            default:       prox_estado = INICIAL;
        endcase
    end

    // Moore output decode.
    always_comb begin
        zera_e     = 1'b0;
        conta_e    = 1'b0;
        zera_l     = 1'b0;
        conta_l    = 1'b0;
        zera_r     = 1'b0;
        registra_r = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        pronto     = 1'b0;
        timeout    = 1'b0;
        case (estado)
            PREPARA: begin
                zera_e = 1'b1;
                zera_l = 1'b1;
                zera_r = 1'b1;
            end
            INICIA_RODADA: zera_e     = 1'b1;
            REGISTRA:      registra_r = 1'b1;
            PROX_JOGADA:   conta_e    = 1'b1;
            PROX_RODADA:   conta_l    = 1'b1;
            FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FIM_ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
`ifdef CTRL_TIMEOUT_EN
            FIM_TIMEOUT: begin
                errou   = 1'b1;
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule
